ama_riscv_icache: RTL and testbench

- Direct-mapped, read-only instruction cache between the fetch stage and main memory.
- Core side: 32-bit instruction reads over a valid/ready request channel and a valid-only response channel.
- Memory side: line refills of CACHE_LINE_SIZE bits (512) as MEM_TRANSFERS_PER_CL (4) beats of MEM_DATA_BUS bits (128).
- State machine uses cache_state_t: IC_RESET, IC_READY, IC_MISS.

---
 rtl/ama_riscv_icache_pkg.sv | 41 ++++
 rtl/rv_if.sv | 30 +++
 rtl/ama_riscv_icache_refill.sv | 48 ++++
 rtl/ama_riscv_icache.sv | 165 ++++++++++++++++
 tb/tb_ama_riscv_icache.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/ama_riscv_icache_pkg.sv
`default_nettype none
// =============================================================================
// Module  : ama_riscv_icache_pkg
// Brief   : Shared bus widths, cache geometry, address layout and FSM encoding
// Rev     : 1.0
// =============================================================================
package ama_riscv_icache_pkg;

    localparam int CORE_ADDR_BUS_B      = 16;
    localparam int CORE_DATA_BUS        = 32;
    localparam int MEM_ADDR_BUS         = 12;
    localparam int MEM_DATA_BUS         = 128;
    localparam int CACHE_LINE_SIZE      = 512;
    localparam int MEM_TRANSFERS_PER_CL = CACHE_LINE_SIZE / MEM_DATA_BUS;
    localparam int BEAT_CNT_W           = $clog2(MEM_TRANSFERS_PER_CL);
    localparam int CL_BYTE_W            = $clog2(CACHE_LINE_SIZE / 8);
    localparam int TAG_W                = CORE_ADDR_BUS_B - CL_BYTE_W;

    localparam int ICACHE_SETS = 4;
    localparam int IC_IDX_W    = $clog2(ICACHE_SETS);

    typedef logic [1:0] cache_state_t;
    localparam cache_state_t IC_RESET = 2'd0;
    localparam cache_state_t IC_READY = 2'd1;
    localparam cache_state_t IC_MISS  = 2'd2;

    // Byte-address layout of a core fetch for the default geometry
    typedef struct packed {
        logic [TAG_W-IC_IDX_W-1:0] tag;
        logic [IC_IDX_W-1:0]       idx;
        logic [BEAT_CNT_W-1:0]     beat;
        logic [1:0]                word;
        logic [1:0]                byte_off;
    } ic_addr_t;

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv_if.sv
`default_nettype none
// =============================================================================
// Module  : rv_if / rv_if_da
// Brief   : Valid/ready channel, plain data and address+write-data flavours
// Rev     : 1.0
// =============================================================================
interface rv_if #(
    parameter int DW = 32
) ();
    logic          valid;
    logic          ready;
    logic [DW-1:0] data;

    modport TX (output valid, output data, input ready);
    modport RX (input valid, input data, output ready);
endinterface

interface rv_if_da #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    logic          valid;
    logic          ready;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;

    modport TX (output valid, output addr, output wdata, input ready);
    modport RX (input valid, input addr, input wdata, output ready);
endinterface
`default_nettype wire

// File: rtl/ama_riscv_icache_refill.sv
`default_nettype none
// =============================================================================
// Module  : ama_riscv_icache_refill
// Brief   : Counts refill beats and assembles them into one cache line
// Rev     : 1.0
// =============================================================================
module ama_riscv_icache_refill
    import ama_riscv_icache_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       beat_valid,
    input  logic [MEM_DATA_BUS-1:0]    beat_data,
    output logic [CACHE_LINE_SIZE-1:0] line,
    output logic                       done
);
    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(MEM_TRANSFERS_PER_CL - 1);

    logic [BEAT_CNT_W-1:0]      r_beat_cnt;
    logic [CACHE_LINE_SIZE-1:0] r_line;

    // The final beat is merged combinationally so the array can take the
    // complete line at the end of that same cycle.
    always_comb begin
        line = r_line;
        if (beat_valid) begin
            line[int'(r_beat_cnt) * MEM_DATA_BUS +: MEM_DATA_BUS] = beat_data;
        end
    end

    assign done = beat_valid && (r_beat_cnt == LAST_BEAT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat_cnt <= '0;
        end else if (beat_valid) begin
            r_beat_cnt <= r_beat_cnt + BEAT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (beat_valid) begin
            r_line <= line;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ama_riscv_icache.sv
`default_nettype none
// =============================================================================
// Module  : ama_riscv_icache
// Brief   : Direct-mapped read-only instruction cache with line refill;
//           defining ICACHE_STATS_EN adds saturating hit_cnt / miss_cnt outputs
// Rev     : 1.0
// =============================================================================
module ama_riscv_icache
    import ama_riscv_icache_pkg::*;
#(
    parameter int SETS = ICACHE_SETS
) (
    input  logic        clk,
    input  logic        rst,
    rv_if.RX            req,
    rv_if.TX            rsp,
    rv_if_da.TX         mem_req,
    rv_if.RX            mem_rsp
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);
    localparam int IDX_W    = $clog2(SETS);
    localparam int TAG_BITS = TAG_W - IDX_W;
    localparam int WSEL_W   = CL_BYTE_W - 2;

    if (!is_pow2(SETS) || (SETS < 2)) begin : g_sets_check
        $error("ama_riscv_icache: SETS must be a power of two and at least 2");
    end

    cache_state_t               r_state;
    logic [SETS-1:0]            r_valid;
    logic [TAG_BITS-1:0]        r_tag  [SETS];
    logic [CACHE_LINE_SIZE-1:0] r_data [SETS];
    logic [CORE_ADDR_BUS_B-1:2] r_addr;
    logic                       r_pending;
    logic                       r_mem_sent;

    logic [IDX_W-1:0]           w_idx;
    logic [TAG_BITS-1:0]        w_tag;
    logic [WSEL_W-1:0]          w_wsel;
    logic                       w_hit;
    logic                       w_lookup;
    logic                       w_rsp_valid;
    logic                       w_miss;
    logic                       w_accept;
    logic                       w_beat;
    logic                       w_fill_done;
    logic [CACHE_LINE_SIZE-1:0] w_fill_line;
    logic                       w_unused;

    assign w_idx  = r_addr[CL_BYTE_W +: IDX_W];
    assign w_tag  = r_addr[CORE_ADDR_BUS_B-1 -: TAG_BITS];
    assign w_wsel = r_addr[CL_BYTE_W-1:2];

    assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_lookup    = r_pending && (r_state == IC_READY);
    assign w_rsp_valid = w_lookup && w_hit;
    assign w_miss      = w_lookup && !w_hit;
    assign w_accept    = req.valid && req.ready;

    assign req.ready = (r_state == IC_READY) && !(r_pending && !w_hit);

    assign rsp.valid = w_rsp_valid;
    assign rsp.data  = w_rsp_valid ?
                       r_data[w_idx][int'(w_wsel) * CORE_DATA_BUS +: CORE_DATA_BUS] : '0;

    // The pending address doubles as the refill address while in IC_MISS
    assign mem_req.valid = (r_state == IC_MISS) && !r_mem_sent;
    assign mem_req.addr  = {w_tag, w_idx, {BEAT_CNT_W{1'b0}}};
    assign mem_req.wdata = '0;

    assign mem_rsp.ready = (r_state == IC_MISS) && r_mem_sent;
    assign w_beat        = mem_rsp.valid && mem_rsp.ready;

    assign w_unused = ^{req.data[1:0], rsp.ready};

    ama_riscv_icache_refill u_refill (
        .clk        (clk),
        .rst        (rst),
        .beat_valid (w_beat),
        .beat_data  (mem_rsp.data),
        .line       (w_fill_line),
        .done       (w_fill_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IC_RESET;
            r_valid    <= '0;
            r_pending  <= 1'b0;
            r_mem_sent <= 1'b0;
        end else begin
            case (r_state)
                IC_RESET: r_state <= IC_READY;
                IC_READY: begin
                    if (w_miss) begin
                        r_state <= IC_MISS;
                    end
                end
                IC_MISS: begin
                    if (mem_req.valid && mem_req.ready) begin
                        r_mem_sent <= 1'b1;
                    end
                    if (w_fill_done) begin
                        r_state        <= IC_READY;
                        r_mem_sent     <= 1'b0;
                        r_valid[w_idx] <= 1'b1;
                    end
                end
                default: r_state <= IC_RESET;
            endcase

            // A missed lookup stays pending and is answered after the refill
            if (w_accept) begin
                r_pending <= 1'b1;
            end else if (w_rsp_valid) begin
                r_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr <= req.data[CORE_ADDR_BUS_B-1:2];
        end
        if (w_fill_done) begin
            r_tag[w_idx]  <= w_tag;
            r_data[w_idx] <= w_fill_line;
        end
    end

`ifdef ICACHE_STATS_EN
    logic        r_refilled;
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    // The response right after a refill answers the original miss, not a hit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_refilled <= 1'b0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            r_refilled <= w_fill_done;
            if (w_rsp_valid && !r_refilled && (r_hit_cnt != '1)) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end
            if (w_miss && (r_miss_cnt != '1)) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`endif

    a_beat_after_req: assert property (@(posedge clk) disable iff (rst)
        mem_rsp.valid |-> ((r_state == IC_MISS) && r_mem_sent));

endmodule
`default_nettype wire

// File: tb/tb_ama_riscv_icache.sv
`default_nettype none
// =============================================================================
// Module  : tb_ama_riscv_icache
// Brief   : Directed self-checking bench for ama_riscv_icache
// Rev     : 1.0
// =============================================================================
module tb_ama_riscv_icache;
    import ama_riscv_icache_pkg::*;

    logic clk;
    logic rst;
    int   n_total = 0;
    int   n_bad   = 0;

    rv_if    #(.DW(CORE_ADDR_BUS_B))                    req_if  ();
    rv_if    #(.DW(CORE_DATA_BUS))                      rsp_if  ();
    rv_if_da #(.AW(MEM_ADDR_BUS), .DW(MEM_DATA_BUS))    mreq_if ();
    rv_if    #(.DW(MEM_DATA_BUS))                       mrsp_if ();

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    ama_riscv_icache dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req_if),
        .rsp      (rsp_if),
        .mem_req  (mreq_if),
        .mem_rsp  (mrsp_if)
`ifdef ICACHE_STATS_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Word w of beat b of line la reads as {A, la, b, w}
    function automatic logic [MEM_DATA_BUS-1:0] beat_data(input logic [11:0] la, input int b);
        logic [MEM_DATA_BUS-1:0] d;
        for (int w = 0; w < 4; w++) begin
            d[w*32 +: 32] = {4'hA, la, 8'(b), 8'(w)};
        end
        return d;
    endfunction

    // Issue one fetch; a miss is served after `stall` extra wait cycles on
    // mem_req; rst is pulsed instead of beat number rst_at when rst_at < 4.
    task automatic fetch(input string name, input logic [15:0] a, input bit miss,
                         input logic [11:0] exp_maddr, input logic [31:0] exp_data,
                         input int stall, input int rst_at);
        req_if.valid = 1'b1;
        req_if.data  = a;
        check_val({name, ".req_ready"}, 32'(req_if.ready), 32'd1);
        tick();
        req_if.valid = 1'b0;
        if (!miss) begin
            check_val({name, ".hit_valid"}, 32'(rsp_if.valid), 32'd1);
            check_val({name, ".hit_data"}, rsp_if.data, exp_data);
        end else begin
            check_val({name, ".miss_no_rsp"}, 32'(rsp_if.valid), 32'd0);
            check_val({name, ".miss_not_ready"}, 32'(req_if.ready), 32'd0);
            tick();
            check_val({name, ".mreq_valid"}, 32'(mreq_if.valid), 32'd1);
            check_val({name, ".mreq_addr"}, 32'(mreq_if.addr), 32'(exp_maddr));
            for (int i = 0; i < stall; i++) begin
                tick();
                check_val({name, ".mreq_valid_hold"}, 32'(mreq_if.valid), 32'd1);
                check_val({name, ".mreq_addr_hold"}, 32'(mreq_if.addr), 32'(exp_maddr));
            end
            mreq_if.ready = 1'b1;
            tick();
            mreq_if.ready = 1'b0;
            check_val({name, ".mreq_dropped"}, 32'(mreq_if.valid), 32'd0);
            check_val({name, ".mrsp_ready"}, 32'(mrsp_if.ready), 32'd1);
            for (int b = 0; b < 4; b++) begin
                if (b == rst_at) begin
                    mrsp_if.valid = 1'b0;
                    rst = 1'b1;
                    tick();
                    check_val({name, ".rst_no_rsp"}, 32'(rsp_if.valid), 32'd0);
                    check_val({name, ".rst_mrsp_ready"}, 32'(mrsp_if.ready), 32'd0);
                    check_val({name, ".rst_mreq_valid"}, 32'(mreq_if.valid), 32'd0);
                    tick();
                    rst = 1'b0;
                    check_val({name, ".rst_state_ready"}, 32'(req_if.ready), 32'd0);
                    tick();
                    check_val({name, ".rst_idle_no_rsp"}, 32'(rsp_if.valid), 32'd0);
                    return;
                end
                mrsp_if.valid = 1'b1;
                mrsp_if.data  = beat_data(exp_maddr, b);
                tick();
            end
            mrsp_if.valid = 1'b0;
            check_val({name, ".fill_rsp_valid"}, 32'(rsp_if.valid), 32'd1);
            check_val({name, ".fill_rsp_data"}, rsp_if.data, exp_data);
            check_val({name, ".fill_req_ready"}, 32'(req_if.ready), 32'd1);
        end
        tick();
        check_val({name, ".rsp_pulse"}, 32'(rsp_if.valid), 32'd0);
    endtask

    logic [15:0] hs_addr [3];
    logic [31:0] hs_data [3];

    initial begin
        rst           = 1'b1;
        req_if.valid  = 1'b0;
        req_if.data   = '0;
        rsp_if.ready  = 1'b1;
        mreq_if.ready = 1'b0;
        mrsp_if.valid = 1'b0;
        mrsp_if.data  = '0;
        hs_addr = '{16'h0044, 16'h0048, 16'h0070};
        hs_data = '{32'hA004_0001, 32'hA004_0002, 32'hA004_0300};

        tick();
        tick();
        check_val("reset.req_ready", 32'(req_if.ready), 32'd0);
        check_val("reset.rsp_valid", 32'(rsp_if.valid), 32'd0);
        check_val("reset.rsp_data", rsp_if.data, 32'd0);
        check_val("reset.mreq_valid", 32'(mreq_if.valid), 32'd0);
        check_val("reset.mrsp_ready", 32'(mrsp_if.ready), 32'd0);
        rst = 1'b0;
        check_val("reset.ic_reset_cycle", 32'(req_if.ready), 32'd0);
        tick();
        check_val("reset.ready_after", 32'(req_if.ready), 32'd1);

        fetch("cold", 16'h0040, 1'b1, 12'h004, 32'hA004_0000, 0, 4);
`ifdef ICACHE_STATS_EN
        check_val("stats.miss_after_cold", miss_cnt, 32'd1);
        check_val("stats.hit_after_cold", hit_cnt, 32'd0);
`endif

        for (int i = 0; i < 3; i++) begin
            req_if.valid = 1'b1;
            req_if.data  = hs_addr[i];
            check_val("streak.req_ready", 32'(req_if.ready), 32'd1);
            if (i > 0) begin
                check_val("streak.rsp_valid", 32'(rsp_if.valid), 32'd1);
                check_val("streak.rsp_data", rsp_if.data, hs_data[i-1]);
            end
            tick();
        end
        req_if.valid = 1'b0;
        check_val("streak.last_valid", 32'(rsp_if.valid), 32'd1);
        check_val("streak.last_data", rsp_if.data, hs_data[2]);
        check_val("streak.no_mreq", 32'(mreq_if.valid), 32'd0);
        tick();
        check_val("streak.idle", 32'(rsp_if.valid), 32'd0);
`ifdef ICACHE_STATS_EN
        check_val("stats.hit_after_streak", hit_cnt, 32'd3);
        check_val("stats.miss_after_streak", miss_cnt, 32'd1);
`endif

        fetch("conflict", 16'h0140, 1'b1, 12'h014, 32'hA014_0000, 0, 4);
        fetch("evicted_stall", 16'h0040, 1'b1, 12'h004, 32'hA004_0000, 5, 4);
        fetch("rehit", 16'h004C, 1'b0, 12'h000, 32'hA004_0003, 0, 4);

        fetch("rst_mid", 16'h0080, 1'b1, 12'h008, 32'hA008_0000, 0, 3);
        fetch("after_rst", 16'h0040, 1'b1, 12'h004, 32'hA004_0000, 0, 4);

        fetch("wrap", 16'hFFFC, 1'b1, 12'hFFC, 32'hAFFC_0303, 0, 4);
        fetch("wrap_hit", 16'hFFF8, 1'b0, 12'h000, 32'hAFFC_0302, 0, 4);
        fetch("post_wrap", 16'h0080, 1'b1, 12'h008, 32'hA008_0000, 0, 4);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
